ahb_lite_dbus_master: RTL and testbench
=======================================

// Module: ahb_lite_dbus_master
// PURPOSE
//  Bridges the yadan core LSU data-memory request port onto the AHB-Lite data bus.
//  Turns each core load/store into one single NONSEQ AHB transfer and handles wait states and ERROR responses.
//  Sits directly upstream of the bus decoder and AHB2MEM_RAM.
//  Non-pipelined: at most one transfer is in flight, so the address and data phases of different transfers never overlap.
// PARAMETERS
//  HPROT_VAL    4'b0011  constant HPROT value: data access, privileged
//  ALIGN_CHECK  1        1 = misaligned half/word requests are rejected locally with an error; 0 = issued as-is
// PORTS
//  HCLK         in   1   bus/core clock
//  HRESETn      in   1   asynchronous active-low reset
//  mem_req_i    in   1   core request; held with all fields stable until mem_ack_o
//  mem_we_i     in   1   1 = store, 0 = load
//  mem_addr_i   in   32  byte address
//  mem_size_i   in   3   3'b000 byte, 3'b001 half, 3'b010 word; other codes are treated as word
//  mem_wdata_i  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  mem_ack_o    out  1   one-cycle completion pulse
//  mem_err_o    out  1   valid with mem_ack_o: bus ERROR or misalignment
//  mem_rdata_o  out  32  load data, right-aligned and zero-extended; valid with mem_ack_o
//  stall_o      out  1   mem_req_i & ~mem_ack_o (combinational)
//  HADDR        out  32  AHB address
//  HTRANS       out  2   IDLE 2'b00 or NONSEQ 2'b10 only
//  HWRITE       out  1
//  HSIZE        out  3
//  HBURST       out  3   constant 3'b000 (SINGLE)
//  HPROT        out  4   HPROT_VAL
//  HWDATA       out  32  write data, valid in the data phase
//  HREADY       in   1   transfer-done signal from the slave mux
//  HRDATA       in   32
//  HRESP        in   1   0 = OKAY, 1 = ERROR
// BEHAVIOUR
//  Reset: state IDLE. HADDR=0, HTRANS=IDLE, HWRITE=0, HSIZE=0, HWDATA=0, mem_ack_o=0, mem_err_o=0, mem_rdata_o=0.
//   All address-phase and data-phase outputs are registered.
//  FSM states: IDLE, ADDR, DATA, RESP.
//   IDLE -> ADDR when mem_req_i and the request is aligned.
//     Registers HADDR, HWRITE, HSIZE (= mem_size_i[1:0] with 3'b010 substituted for codes above 2) and HTRANS=NONSEQ.
//     Captures the write data and the address low bits.
//   IDLE -> RESP when mem_req_i, ALIGN_CHECK=1 and the request is misaligned (half: addr[0]; word: addr[1:0]!=0).
//     Sets mem_err_o=1. No bus transfer is issued.
//   ADDR: HTRANS held at NONSEQ until HREADY=1. Then -> DATA.
//     HTRANS goes to IDLE and HWDATA takes the lane-replicated store data:
//       byte {4{b}}, half {2{h}}, word as-is.
//   DATA: waits for HREADY=1. Then -> RESP.
//     mem_err_o=HRESP.
//     mem_rdata_o = HRDATA >> (8*addr[1:0]) for byte/half, masked to 8/16 bits; full HRDATA for word.
//   RESP: mem_ack_o=1 for exactly this one cycle. mem_req_i is ignored in this cycle. -> IDLE.
//  Latency with zero wait states: req seen at cycle 0, NONSEQ at cycle 1, data phase at cycle 2, ack at cycle 3.
//   Each HREADY-low cycle adds one cycle.
//  ERROR handling:
//   First ERROR cycle (HREADY=0, HRESP=1): stay in DATA. HTRANS is already IDLE, which satisfies the two-cycle rule.
//   Second ERROR cycle: capture err=1 and set mem_rdata_o=0.
//  HWDATA holds its value until the next data phase. HADDR, HWRITE and HSIZE hold after NONSEQ (no toggling on IDLE).
//  mem_req_i dropped mid-transfer: the transfer still completes on the bus and the ack is still pulsed.
//  Reset asserted mid-transfer: the in-flight access is dropped and all outputs return to reset values immediately.
//   No ack is produced.
// STRUCTURE
//  Shared package/defs: HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD, HBURST_SINGLE, HRESP_OKAY/ERROR.
//   These go next to the existing yadan defines.
//  One natural sub-module: dbus_lane_align.
//   Combinational write-lane replication and read extraction from (size, addr[1:0]).
//   Reusable by the instruction-fetch master.
//  Top level: FSM plus registered AHB outputs.
// TESTING
//  1 Word store 0xDEADBEEF @0x100, HREADY=1
//     -> NONSEQ at cycle 1 with HSIZE=010, HWDATA=0xDEADBEEF at cycle 2, ack at cycle 3 with err=0.
//  2 Byte store 0xA5 @0x103, then byte load @0x103 against AHB2MEM_RAM
//     -> HWDATA=0xA5A5A5A5, HSIZE=000; load returns mem_rdata_o=0x000000A5.
//  3 Word load @0x200 with 3 HREADY-low cycles in the data phase
//     -> ack at cycle 6, exactly one pulse, HTRANS=IDLE throughout the wait.
//  4 Two-cycle ERROR response on a store @0x4000_0000
//     -> stay in DATA through the first cycle; ack with mem_err_o=1 and rdata=0.
//  5 Half load @0x101 with ALIGN_CHECK=1
//     -> no NONSEQ on the bus; ack with err=1 at cycle 1.
//  6 HRESETn pulsed low during the ADDR phase
//     -> HTRANS=IDLE and mem_ack_o=0 immediately; the next request completes normally.

Source files
------------

// File: rtl/ahb_lite_dbus_master_pkg.sv
// Shared AHB-Lite encodings and request helpers for the yadan data-bus master.
// Sits next to the existing yadan defines; the instruction-fetch master can reuse it.
package ahb_lite_dbus_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } dbus_state_e;

  // Size codes above word are treated as word.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    return (size > HSIZE_WORD) ? HSIZE_WORD : size;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      HSIZE_BYTE: mis = 1'b0;
      HSIZE_HALF: mis = addr_lo[0];
      default:    mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Byte-lane steering between right-aligned core data and the 32-bit AHB data bus.
// Store data is replicated across lanes; load data is shifted down and zero-extended.
module dbus_lane_align
  import ahb_lite_dbus_master_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [31:0] bus_wdata,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    shifted   = bus_rdata >> {addr_lo, 3'b000};
    bus_wdata = wdata;
    rdata     = bus_rdata;
    case (size)
      HSIZE_BYTE: begin
        bus_wdata = {4{wdata[7:0]}};
        rdata     = {24'h0, shifted[7:0]};
      end
      HSIZE_HALF: begin
        bus_wdata = {2{wdata[15:0]}};
        rdata     = {16'h0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_lite_dbus_master.sv
// Non-pipelined AHB-Lite master for the yadan LSU: one SINGLE NONSEQ transfer per core request,
// with wait-state handling, two-cycle ERROR responses and optional local misalignment rejection.
module ahb_lite_dbus_master
  import ahb_lite_dbus_master_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [2:0]  mem_size_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic [31:0] mem_rdata_o,
  output logic        stall_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  dbus_state_e state_q, state_d;

  logic [2:0]  req_size;
  logic        req_misaligned;
  logic [31:0] wdata_q;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign req_size       = norm_size(mem_size_i);
  assign req_misaligned = ALIGN_CHECK && is_misaligned(req_size, mem_addr_i[1:0]);

  assign HBURST  = HBURST_SINGLE;
  assign HPROT   = HPROT_VAL;
  assign stall_o = mem_req_i & ~mem_ack_o;

  // HADDR/HSIZE hold through the data phase, so they double as the captured request.
  dbus_lane_align u_lane_align (
    .size      (HSIZE),
    .addr_lo   (HADDR[1:0]),
    .wdata     (wdata_q),
    .bus_rdata (HRDATA),
    .bus_wdata (lane_wdata),
    .rdata     (lane_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_req_i) state_d = req_misaligned ? ST_RESP : ST_ADDR;
      ST_ADDR: if (HREADY) state_d = ST_DATA;
      ST_DATA: if (HREADY) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR       <= '0;
      HTRANS      <= HTRANS_IDLE;
      HWRITE      <= 1'b0;
      HSIZE       <= HSIZE_BYTE;
      HWDATA      <= '0;
      wdata_q     <= '0;
      mem_ack_o   <= 1'b0;
      mem_err_o   <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      mem_ack_o <= (state_d == ST_RESP);
      case (state_q)
        ST_IDLE: begin
          if (mem_req_i) begin
            if (req_misaligned) begin
              mem_err_o   <= 1'b1;
              mem_rdata_o <= '0;
            end else begin
              HADDR   <= mem_addr_i;
              HWRITE  <= mem_we_i;
              HSIZE   <= req_size;
              HTRANS  <= HTRANS_NONSEQ;
              wdata_q <= mem_wdata_i;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            HWDATA <= lane_wdata;
          end
        end
        ST_DATA: begin
          // A first ERROR cycle has HREADY low, so only the final response cycle lands here.
          if (HREADY) begin
            mem_err_o   <= (HRESP == HRESP_ERROR);
            mem_rdata_o <= (HRESP == HRESP_OKAY) ? lane_rdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_dbus_master.sv
// Scoreboard bench: driver issues core requests and pushes expected responses; a reactive AHB
// slave serves a word memory; a monitor pops and compares on every mem_ack_o.
module tb_ahb_lite_dbus_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        mem_req_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [2:0]  mem_size_i;
  logic        mem_ack_o, mem_err_o, stall_o;
  logic [31:0] mem_rdata_o;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb_lite_dbus_master #(.HPROT_VAL(4'b0011), .ALIGN_CHECK(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_size_i(mem_size_i), .mem_wdata_i(mem_wdata_i),
    .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o), .mem_rdata_o(mem_rdata_o), .stall_o(stall_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] hwdata;
    int          aw;
    int          dw;
    logic        err;
  } plan_t;

  typedef struct {
    logic        err;
    bit          chk_rdata;
    logic [31:0] rdata;
    int          lat;
    int          issue;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int checks = 0;
  int failures = 0;
  int cycle_cnt = 0;

  always @(posedge HCLK) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Reference model: a flat byte memory seen through the core interface.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_byte(a + 32'(i))) << (8 * i));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  // ---------------- AHB slave (word memory, lane writes, scripted waits/errors) ----------------
  initial begin : slave
    plan_t       s_plan;
    int          s_phase, s_aw, s_dw;
    bit          s_err_first;
    logic [31:0] word, wa;
    int          lane;
    s_phase = 0; s_aw = 0; s_dw = 0; s_err_first = 0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(negedge HCLK);
      HRDATA = $urandom;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (!HRESETn) begin
        s_phase = 0;
      end else begin
        if (s_phase == 0 && HTRANS == 2'b10) begin
          if (plan_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_nonseq actual_haddr=0x%08h expected=no transfer", HADDR);
            s_plan = '{we: HWRITE, addr: HADDR, size: HSIZE, hwdata: '0, aw: 0, dw: 0, err: 1'b1};
          end else begin
            s_plan = plan_q.pop_front();
            check("haddr", HADDR, s_plan.addr);
            check("hwrite", 32'(HWRITE), 32'(s_plan.we));
            check("hsize", 32'(HSIZE), 32'(s_plan.size));
          end
          s_aw = s_plan.aw;
          s_phase = 1;
        end
        case (s_phase)
          1: begin
            check("htrans_addr_phase", 32'(HTRANS), 32'h2);
            if (s_aw > 0) begin
              HREADY = 1'b0;
              s_aw--;
            end else begin
              s_phase = 2;
              s_dw = s_plan.dw;
              s_err_first = 0;
            end
          end
          2: begin
            check("htrans_data_phase", 32'(HTRANS), 32'h0);
            if (s_dw > 0) begin
              HREADY = 1'b0;
              s_dw--;
            end else if (s_plan.err && !s_err_first) begin
              HREADY = 1'b0;
              HRESP = 1'b1;
              s_err_first = 1;
            end else if (s_plan.err) begin
              HRESP = 1'b1;
              s_phase = 0;
            end else begin
              wa = {s_plan.addr[31:2], 2'b00};
              word = slv_mem.exists(wa) ? slv_mem[wa] : 32'h0;
              lane = int'(s_plan.addr[1:0]);
              if (s_plan.we) begin
                check("hwdata", HWDATA, s_plan.hwdata);
                case (s_plan.size)
                  3'd0:    word[8*lane +: 8]  = HWDATA[8*lane +: 8];
                  3'd1:    word[8*lane +: 16] = HWDATA[8*lane +: 16];
                  default: word = HWDATA;
                endcase
                slv_mem[wa] = word;
              end else begin
                HRDATA = word;
              end
              s_phase = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- Monitor: pops expected responses on every ack ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && mem_ack_o) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack actual=1 expected=0 (cycle %0d)", cycle_cnt);
        end else begin
          e = exp_q.pop_front();
          check("ack_err", 32'(mem_err_o), 32'(e.err));
          if (e.chk_rdata) check("ack_rdata", mem_rdata_o, e.rdata);
          check("ack_latency", 32'(cycle_cnt - e.issue), 32'(e.lat));
        end
      end
    end
  end

  // ---------------- Driver ----------------
  // Called just after a falling edge; returns after the ack plus a short idle gap.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input int aw, input int dw,
                        input logic err, input bit drop_early);
    logic [2:0] ns;
    bit         mis;
    int         n;
    plan_t      p;
    exp_t       e;
    ns  = (size > 3'd2) ? 3'd2 : size;
    mis = (ns == 3'd1 && addr[0]) || (ns == 3'd2 && addr[1:0] != 2'b00);
    e.issue = cycle_cnt;
    if (mis) begin
      e.err = 1'b1; e.chk_rdata = 1'b0; e.rdata = '0; e.lat = 1;
    end else begin
      p.we = we; p.addr = addr; p.size = ns; p.aw = aw; p.dw = dw; p.err = err;
      p.hwdata = (ns == 3'd0) ? {4{wdata[7:0]}} : (ns == 3'd1) ? {2{wdata[15:0]}} : wdata;
      plan_q.push_back(p);
      e.lat = 3 + aw + dw + (err ? 1 : 0);
      e.err = err;
      if (err) begin
        e.chk_rdata = 1'b1; e.rdata = '0;
      end else if (we) begin
        e.chk_rdata = 1'b0; e.rdata = '0;
        ref_store(addr, 1 << ns, wdata);
      end else begin
        e.chk_rdata = 1'b1;
        e.rdata = ref_load(addr, 1 << ns);
      end
    end
    exp_q.push_back(e);
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_size_i = size; mem_wdata_i = wdata;
    #1 check("stall_while_req", 32'(stall_o), 32'h1);
    n = 0;
    while (mem_ack_o !== 1'b1 && n < 100) begin
      @(negedge HCLK);
      n++;
      if (drop_early && !mis && n == 1) begin
        mem_req_i = 1'b0; mem_addr_i = $urandom; mem_wdata_i = $urandom; mem_we_i = ~we;
      end
    end
    if (mem_ack_o !== 1'b1) begin
      checks++; failures++;
      $display("FAIL ack_timeout actual=no ack expected=ack within 100 cycles (addr 0x%08h)", addr);
    end
    mem_req_i = 1'b0;
    #1 check("stall_after_ack", 32'(stall_o), 32'h0);
    repeat (1 + $urandom_range(0, 2)) @(negedge HCLK);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_haddr"}, HADDR, 32'h0);
    check({tag, "_htrans"}, 32'(HTRANS), 32'h0);
    check({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
    check({tag, "_hsize"}, 32'(HSIZE), 32'h0);
    check({tag, "_hwdata"}, HWDATA, 32'h0);
    check({tag, "_ack"}, 32'(mem_ack_o), 32'h0);
    check({tag, "_err"}, 32'(mem_err_o), 32'h0);
    check({tag, "_rdata"}, mem_rdata_o, 32'h0);
  endtask

  initial begin : main
    plan_t p;
    logic [31:0] a;
    HRESETn = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_size_i = '0; mem_wdata_i = '0;
    repeat (3) @(negedge HCLK);
    check_reset_values("reset");
    check("hburst", 32'(HBURST), 32'h0);
    check("hprot", 32'(HPROT), 32'h3);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);

    // Word store, zero waits
    do_req(1'b1, 32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
    // Byte store then byte load at the same address
    do_req(1'b1, 32'h0000_0103, 3'b000, 32'h0000_00A5, 0, 0, 1'b0, 1'b0);
    do_req(1'b0, 32'h0000_0103, 3'b000, 32'h0, 0, 0, 1'b0, 1'b0);
    // Word load with three data-phase wait states
    do_req(1'b0, 32'h0000_0200, 3'b010, 32'h0, 0, 3, 1'b0, 1'b0);
    // Two-cycle ERROR on a store
    do_req(1'b1, 32'h4000_0000, 3'b010, 32'h1234_5678, 0, 0, 1'b1, 1'b0);
    // Misaligned half load is rejected without a bus transfer
    do_req(1'b0, 32'h0000_0101, 3'b001, 32'h0, 0, 0, 1'b0, 1'b0);
    // Oversized size code behaves as word; address-phase wait states
    do_req(1'b0, 32'h0000_0100, 3'b111, 32'h0, 2, 1, 1'b0, 1'b0);

    // Reset pulsed during the address phase
    p = '{we: 1'b0, addr: 32'h0000_0300, size: 3'd2, hwdata: '0, aw: 3, dw: 0, err: 1'b0};
    plan_q.push_back(p);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0300; mem_size_i = 3'b010;
    @(negedge HCLK);
    check("htrans_before_reset", 32'(HTRANS), 32'h2);
    #1 HRESETn = 1'b0;
    #1 check_reset_values("mid_reset");
    mem_req_i = 1'b0;
    plan_q.delete();
    @(negedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    do_req(1'b0, 32'h0000_0100, 3'b010, 32'h0, 0, 0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 7) == 0) ? (32'h4000_0000 + 32'($urandom_range(0, 15)))
                                       : (32'h0000_0100 + 32'($urandom_range(0, 63)));
      do_req(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0));
    end

    repeat (3) @(negedge HCLK);
    if (exp_q.size() != 0 || plan_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL leftover actual=%0d pending expected=0", exp_q.size() + plan_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
